demux_1to4_buf: RTL and testbench

DEMUX_1TO4_BUF -- requirements
Module: demux_1to4_buf

---
 rtl/demux_1to4_buf.sv | 78 +++++++
 tb/tb_demux_1to4_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf
//   Routes one input word stream to one of four single-entry output
//   channels. The destination comes either from sel_in or from an internal
//   round-robin pointer (auto_in=1). Each channel is a 1-deep holding
//   register with its own valid/ready handshake toward its consumer.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   d_in         input word (WIDTH bits)
//   valid_in     d_in is valid this cycle
//   ready_out    the selected destination can take d_in this cycle
//   sel_in       destination channel when auto_in=0
//   auto_in      1: destination is the round-robin pointer, 0: sel_in
//   q_out        channel k data at [k*WIDTH +: WIDTH]
//   q_valid_out  bit k: channel k holds a word
//   q_ready_in   bit k: consumer k takes the word this cycle
//   ptr_out      current round-robin pointer
//   acc_cnt_out  number of accepted input words, saturating at 16'hFFFF
module demux_1to4_buf #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     d_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [1:0]           sel_in,
  input  logic                 auto_in,
  output logic [4*WIDTH-1:0]   q_out,
  output logic [3:0]           q_valid_out,
  input  logic [3:0]           q_ready_in,
  output logic [1:0]           ptr_out,
  output logic [15:0]          acc_cnt_out
);

  logic [1:0] dst;
  logic       accept;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign dst = auto_in ? ptr_out : sel_in;

  // Only the selected channel gates the input: a full, non-popping
  // destination stalls the stream even when other channels are empty.
  assign ready_out = ~q_valid_out[dst] | q_ready_in[dst];
  assign accept    = valid_in & ready_out;

  // Channel registers, pointer and counter all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_out       <= '0;
      q_valid_out <= 4'b0000;
      ptr_out     <= 2'd0;
      acc_cnt_out <= 16'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (dst == k[1:0])) begin
          // An accept wins over a pop on the same channel, so a word can
          // be replaced back-to-back without the valid flag dropping.
          q_out[k*WIDTH +: WIDTH] <= d_in;
          q_valid_out[k]          <= 1'b1;
        end else if (q_valid_out[k] && q_ready_in[k]) begin
          q_valid_out[k]          <= 1'b0;
        end
      end
      if (accept && auto_in) begin
        ptr_out <= ptr_out + 2'd1;
      end
      if (accept) begin
        acc_cnt_out <= sat_inc(acc_cnt_out);
      end
    end
  end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Testbench for demux_1to4_buf: directed stimulus pushes the word expected
// on each channel into a per-channel queue; a monitor pops and compares on
// every output handshake. Register-level checks cover reset, stalling,
// pointer behaviour and counter saturation.
module tb_demux_1to4_buf;

  logic        clk;
  logic        rst;
  logic [7:0]  d_in;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  sel_in;
  logic        auto_in;
  logic [31:0] q_out;
  logic [3:0]  q_valid_out;
  logic [3:0]  q_ready_in;
  logic [1:0]  ptr_out;
  logic [15:0] acc_cnt_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] sb2[$];
  logic [7:0] sb3[$];

  demux_1to4_buf #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .d_in        (d_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .sel_in      (sel_in),
    .auto_in     (auto_in),
    .q_out       (q_out),
    .q_valid_out (q_valid_out),
    .q_ready_in  (q_ready_in),
    .ptr_out     (ptr_out),
    .acc_cnt_out (acc_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input logic [7:0] v);
    case (ch)
      0: sb0.push_back(v);
      1: sb1.push_back(v);
      2: sb2.push_back(v);
      default: sb3.push_back(v);
    endcase
  endtask

  task automatic flush_exp();
    sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
  endtask

  // Monitor: a pop happens on the next rising edge when valid & ready are
  // both high at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (q_valid_out[k] && q_ready_in[k]) begin
          logic [7:0] exp_v;
          int sz;
          case (k)
            0: sz = sb0.size();
            1: sz = sb1.size();
            2: sz = sb2.size();
            default: sz = sb3.size();
          endcase
          if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_ch%0d: got %0h expected no word", k, q_out[k*8 +: 8]);
          end else begin
            case (k)
              0: exp_v = sb0.pop_front();
              1: exp_v = sb1.pop_front();
              2: exp_v = sb2.pop_front();
              default: exp_v = sb3.pop_front();
            endcase
            chk($sformatf("pop_ch%0d", k), {24'd0, q_out[k*8 +: 8]}, {24'd0, exp_v});
          end
        end
      end
    end
  end

  initial begin
    int exp_ptr[5] = '{0, 1, 2, 3, 0};

    rst = 1'b1; d_in = 8'h00; valid_in = 1'b0; sel_in = 2'd0;
    auto_in = 1'b0; q_ready_in = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_qvalid", {28'd0, q_valid_out}, 32'h0);
    chk("rst_qout",   q_out, 32'h0);
    chk("rst_ptr",    {30'd0, ptr_out}, 32'd0);
    chk("rst_cnt",    {16'd0, acc_cnt_out}, 32'd0);
    chk("rst_ready",  {31'd0, ready_out}, 32'd1);

    // Single word to channel 2
    auto_in = 1'b0; sel_in = 2'd2; d_in = 8'hA5; valid_in = 1'b1;
    push_exp(2, 8'hA5);
    #1 chk("a5_ready", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0;
    #1;
    chk("a5_qvalid", {28'd0, q_valid_out}, 32'h4);
    chk("a5_q2",     {24'd0, q_out[23:16]}, 32'hA5);
    chk("a5_cnt",    {16'd0, acc_cnt_out}, 32'd1);
    chk("a5_ptr",    {30'd0, ptr_out}, 32'd0);

    // Channel 2 full and not popping: input stalls
    d_in = 8'h77; valid_in = 1'b1;
    #1 chk("stall_ready", {31'd0, ready_out}, 32'd0);
    tick();
    #1;
    chk("stall_cnt", {16'd0, acc_cnt_out}, 32'd1);
    chk("stall_q2",  {24'd0, q_out[23:16]}, 32'hA5);
    // Pop A5 and load 3C on the same edge
    q_ready_in = 4'b0100; d_in = 8'h3C;
    push_exp(2, 8'h3C);
    #1 chk("replace_ready", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0; q_ready_in = 4'b0000;
    #1;
    chk("replace_qvalid", {28'd0, q_valid_out}, 32'h4);
    chk("replace_q2",     {24'd0, q_out[23:16]}, 32'h3C);
    chk("replace_cnt",    {16'd0, acc_cnt_out}, 32'd2);
    q_ready_in = 4'b1111;
    tick();
    #1 chk("drain_qvalid", {28'd0, q_valid_out}, 32'h0);

    // Round robin with all consumers ready
    auto_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_ptr%0d", i), {30'd0, ptr_out}, exp_ptr[i]);
      d_in = 8'(i + 1); valid_in = 1'b1;
      push_exp(exp_ptr[i], 8'(i + 1));
      tick();
    end
    valid_in = 1'b0;
    #1;
    chk("rr_ptr_end", {30'd0, ptr_out}, 32'd1);
    chk("rr_cnt",     {16'd0, acc_cnt_out}, 32'd7);
    tick();
    #1 chk("rr_qvalid", {28'd0, q_valid_out}, 32'h0);

    // Build ptr=3 with channel 3 full, consumers idle
    q_ready_in = 4'b0000;
    auto_in = 1'b0; sel_in = 2'd3; d_in = 8'h33; valid_in = 1'b1;
    push_exp(3, 8'h33);
    tick();
    auto_in = 1'b1; d_in = 8'h11; push_exp(1, 8'h11);
    tick();
    d_in = 8'h22; push_exp(2, 8'h22);
    tick();
    d_in = 8'h99;
    #1;
    chk("blk_ptr",   {30'd0, ptr_out}, 32'd3);
    chk("blk_ready", {31'd0, ready_out}, 32'd0);
    tick();
    #1;
    chk("blk_ptr_hold", {30'd0, ptr_out}, 32'd3);
    chk("blk_cnt",      {16'd0, acc_cnt_out}, 32'd10);
    chk("blk_qvalid",   {28'd0, q_valid_out}, 32'hE);

    // Reset beats a simultaneous accept and pops
    rst = 1'b1; valid_in = 1'b1; d_in = 8'hEE; q_ready_in = 4'b1111;
    flush_exp();
    tick();
    rst = 1'b0; valid_in = 1'b0; q_ready_in = 4'b0000;
    #1;
    chk("rst2_qvalid", {28'd0, q_valid_out}, 32'h0);
    chk("rst2_qout",   q_out, 32'h0);
    chk("rst2_ptr",    {30'd0, ptr_out}, 32'd0);
    chk("rst2_cnt",    {16'd0, acc_cnt_out}, 32'd0);
    chk("rst2_ready",  {31'd0, ready_out}, 32'd1);

    // Streaming into channel 0 up to counter saturation
    auto_in = 1'b0; sel_in = 2'd0; q_ready_in = 4'b0001; valid_in = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      d_in = 8'(i);
      push_exp(0, 8'(i));
      tick();
    end
    #1;
    chk("sat_fffe", {16'd0, acc_cnt_out}, 32'hFFFE);
    chk("sat_ptr",  {30'd0, ptr_out}, 32'd0);
    d_in = 8'hF1; push_exp(0, 8'hF1);
    tick();
    #1 chk("sat_ffff", {16'd0, acc_cnt_out}, 32'hFFFF);
    d_in = 8'hF2; push_exp(0, 8'hF2);
    tick();
    #1 chk("sat_hold", {16'd0, acc_cnt_out}, 32'hFFFF);
    valid_in = 1'b0;
    tick();
    #1;
    chk("end_qvalid", {28'd0, q_valid_out}, 32'h0);
    chk("end_sb_left", sb0.size() + sb1.size() + sb2.size() + sb3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
